// File: rtl/lmc1992_pkg.sv
// lmc1992_pkg: shared constants for the LMC1992 Microwire receiver.
//   Frame address, function codes, code limits, reset values, receive
//   state encoding and the Q15 fine-attenuation coefficient LUT.
package lmc1992_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

  localparam logic [1:0] LMC_ADDR   = 2'b10;

  localparam logic [2:0] FN_MIX     = 3'b000;
  localparam logic [2:0] FN_BASS    = 3'b001;
  localparam logic [2:0] FN_TREBLE  = 3'b010;
  localparam logic [2:0] FN_MASTER  = 3'b011;
  localparam logic [2:0] FN_RIGHT   = 3'b100;
  localparam logic [2:0] FN_LEFT    = 3'b101;

  localparam logic [5:0] MAX_MASTER = 6'd40;
  localparam logic [4:0] MAX_LR     = 5'd20;
  localparam logic [3:0] MAX_TONE   = 4'd12;

  localparam logic [5:0] RST_MASTER = 6'd40;
  localparam logic [4:0] RST_LR     = 5'd20;
  localparam logic [3:0] RST_TONE   = 4'd6;
  localparam logic [1:0] RST_MIX    = 2'd1;

  localparam logic [3:0] FRAME_BITS = 4'd11;
  localparam logic [3:0] CNT_MAX    = 4'd15;

  // Fine attenuation within one 6 dB step: 0, -2 or -4 dB in Q15.
  function automatic logic signed [15:0] coef_q15(input logic [2:0] rem);
    case (rem)
      3'd2:    coef_q15 = 16'sd26029;
      3'd4:    coef_q15 = 16'sd20675;
      default: coef_q15 = 16'sd32767;
    endcase
  endfunction

endpackage

// File: rtl/lmc1992_gain.sv
// lmc1992_gain: one channel of the 3-stage attenuation pipeline.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_master       : effective master code 0..40
//   i_lr           : effective left/right code 0..20
//   i_audio        : unsigned 8-bit sample, offset 128
//   o_audio        : signed 16-bit attenuated sample (3-cycle latency)
module lmc1992_gain
  import lmc1992_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [5:0]         i_master,
  input  logic [4:0]         i_lr,
  input  logic [7:0]         i_audio,
  output logic signed [15:0] o_audio
);

  logic [6:0]         w_att_m;
  logic [6:0]         w_att_lr;
  logic [6:0]         w_att;
  logic [4:0]         w_sh;
  logic [2:0]         w_rem;
  logic signed [7:0]  w_s;
  logic signed [22:0] w_s_ext;
  logic signed [22:0] w_c_ext;
  logic signed [22:0] w_p;

  logic signed [7:0]  r_s1_s;
  logic [4:0]         r_s1_sh;
  logic [2:0]         r_s1_rem;
  logic signed [15:0] r_s2_q;
  logic [4:0]         r_s2_sh;
  logic signed [15:0] r_out;

  // Attenuation in dB is twice each code's distance from full scale.
  assign w_att_m  = {(MAX_MASTER - i_master), 1'b0};
  assign w_att_lr = {1'b0, (MAX_LR - i_lr), 1'b0};
  assign w_att    = w_att_m + w_att_lr;
  assign w_sh     = 5'(w_att / 7'd6);
  assign w_rem    = 3'(w_att % 7'd6);
  // Removing the 128 offset is an MSB flip.
  assign w_s      = signed'(i_audio ^ 8'h80);

  assign w_s_ext  = 23'(r_s1_s);
  assign w_c_ext  = 23'(coef_q15(r_s1_rem));
  assign w_p      = w_s_ext * w_c_ext;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_s   <= '0;
      r_s1_sh  <= '0;
      r_s1_rem <= '0;
      r_s2_q   <= '0;
      r_s2_sh  <= '0;
      r_out    <= '0;
    end else begin
      r_s1_s   <= w_s;
      r_s1_sh  <= w_sh;
      r_s1_rem <= w_rem;
      r_s2_q   <= w_p[22:7];
      r_s2_sh  <= r_s1_sh;
      if (r_s2_sh >= 5'd16) r_out <= '0;
      else                  r_out <= r_s2_q >>> r_s2_sh;
    end
  end

  assign o_audio = r_out;

endmodule

// File: rtl/lmc1992.sv
// lmc1992: Microwire receiver, command decoder, volume/tone/mix registers
//   and stereo attenuation for the DMA-sound path.
//   clk32, resb           : 32 MHz clock, async active-low reset
//   mw_clk/mw_data/mw_en_n: Microwire pins (asynchronous, synchronised here)
//   audio_in_l/r          : unsigned 8-bit samples; audio_out_l/r signed 16-bit
//   master_vol, left_vol, right_vol, bass, treble, mix : register outputs
//   frame_ok / frame_err  : one-cycle accept / reject pulses
// Build option: define LMC_RAMP_EN to ramp the gain codes one step every
//   RAMP_DIV cycles instead of applying them immediately.
module lmc1992
  import lmc1992_pkg::*;
`ifdef LMC_RAMP_EN
#(
  parameter int RAMP_DIV = 32000
)
`endif
(
  input  logic               clk32,
  input  logic               resb,
  input  logic               mw_clk,
  input  logic               mw_data,
  input  logic               mw_en_n,
  input  logic [7:0]         audio_in_l,
  input  logic [7:0]         audio_in_r,
  output logic signed [15:0] audio_out_l,
  output logic signed [15:0] audio_out_r,
  output logic [5:0]         master_vol,
  output logic [4:0]         left_vol,
  output logic [4:0]         right_vol,
  output logic [3:0]         bass,
  output logic [3:0]         treble,
  output logic [1:0]         mix,
  output logic               frame_ok,
  output logic               frame_err
);

  // state  | meaning
  // IDLE   | waiting for mw_en_n to fall
  // SHIFT  | inside a frame, clocking bits in on mw_clk rising edges
  rx_state_t r_state, w_state_nxt;

  logic [1:0]  r_clk_sync, r_dat_sync, r_en_sync;
  logic        r_clk_d, r_en_d;
  logic        w_clk_rise, w_en_fall, w_en_rise;
  logic        w_start, w_shift, w_eval;
  logic [10:0] r_sr, w_sr_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  w_addr;
  logic [2:0]  w_fn;
  logic [5:0]  w_data;
  logic        w_valid;
  logic [5:0]  r_master, w_eff_master;
  logic [4:0]  r_left, r_right, w_eff_left, w_eff_right;
  logic [3:0]  r_bass, r_treble;
  logic [1:0]  r_mix;
  logic        r_ok, r_err;

  // en synchronisers reset high so releasing reset is not seen as a frame start.
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_clk_sync <= 2'b00;
      r_dat_sync <= 2'b00;
      r_en_sync  <= 2'b11;
      r_clk_d    <= 1'b0;
      r_en_d     <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], mw_clk};
      r_dat_sync <= {r_dat_sync[0], mw_data};
      r_en_sync  <= {r_en_sync[0], mw_en_n};
      r_clk_d    <= r_clk_sync[1];
      r_en_d     <= r_en_sync[1];
    end
  end

  assign w_clk_rise = r_clk_sync[1] & ~r_clk_d;
  assign w_en_fall  = ~r_en_sync[1] & r_en_d;
  assign w_en_rise  = r_en_sync[1] & ~r_en_d;

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_en_fall) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_en_rise) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start = 1'b0;
    w_shift = 1'b0;
    w_eval  = 1'b0;
    case (r_state)
      ST_IDLE:  w_start = w_en_fall;
      ST_SHIFT: begin
        w_shift = w_clk_rise;
        w_eval  = w_en_rise;
      end
      default: ;
    endcase
  end

  // Evaluation looks at the post-shift values so a final bit arriving with
  // the closing enable edge is still part of the frame.
  assign w_sr_nxt  = w_shift ? {r_sr[9:0], r_dat_sync[1]} : r_sr;
  assign w_cnt_nxt = w_start ? 4'd0 :
                     (w_shift && (r_cnt != CNT_MAX)) ? r_cnt + 4'd1 : r_cnt;

  assign w_addr  = w_sr_nxt[10:9];
  assign w_fn    = w_sr_nxt[8:6];
  assign w_data  = w_sr_nxt[5:0];
  assign w_valid = (w_cnt_nxt >= FRAME_BITS) && (w_addr == LMC_ADDR) &&
                   (w_fn <= FN_LEFT);

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_sr     <= '0;
      r_cnt    <= '0;
      r_master <= RST_MASTER;
      r_left   <= RST_LR;
      r_right  <= RST_LR;
      r_bass   <= RST_TONE;
      r_treble <= RST_TONE;
      r_mix    <= RST_MIX;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_sr  <= w_sr_nxt;
      r_cnt <= w_cnt_nxt;
      r_ok  <= w_eval & w_valid;
      r_err <= w_eval & ~w_valid;
      if (w_eval && w_valid) begin
        case (w_fn)
          FN_MIX:    r_mix    <= w_data[1:0];
          FN_BASS:   r_bass   <= (w_data[3:0] > MAX_TONE) ? MAX_TONE : w_data[3:0];
          FN_TREBLE: r_treble <= (w_data[3:0] > MAX_TONE) ? MAX_TONE : w_data[3:0];
          FN_MASTER: r_master <= (w_data > MAX_MASTER) ? MAX_MASTER : w_data;
          FN_RIGHT:  r_right  <= (w_data[4:0] > MAX_LR) ? MAX_LR : w_data[4:0];
          FN_LEFT:   r_left   <= (w_data[4:0] > MAX_LR) ? MAX_LR : w_data[4:0];
          default: ;
        endcase
      end
    end
  end

`ifdef LMC_RAMP_EN
  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  logic [DIV_W-1:0] r_div;
  logic [5:0]       r_eff_master;
  logic [4:0]       r_eff_left, r_eff_right;
  logic             w_tick;

  assign w_tick = (r_div == '0);

  // The divider free-runs so a retarget does not restart the step period.
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_div        <= DIV_W'(RAMP_DIV - 1);
      r_eff_master <= RST_MASTER;
      r_eff_left   <= RST_LR;
      r_eff_right  <= RST_LR;
    end else begin
      r_div <= w_tick ? DIV_W'(RAMP_DIV - 1) : r_div - 1'b1;
      if (w_tick) begin
        if (r_eff_master < r_master)      r_eff_master <= r_eff_master + 6'd1;
        else if (r_eff_master > r_master) r_eff_master <= r_eff_master - 6'd1;
        if (r_eff_left < r_left)          r_eff_left   <= r_eff_left + 5'd1;
        else if (r_eff_left > r_left)     r_eff_left   <= r_eff_left - 5'd1;
        if (r_eff_right < r_right)        r_eff_right  <= r_eff_right + 5'd1;
        else if (r_eff_right > r_right)   r_eff_right  <= r_eff_right - 5'd1;
      end
    end
  end

  assign w_eff_master = r_eff_master;
  assign w_eff_left   = r_eff_left;
  assign w_eff_right  = r_eff_right;
`else
  assign w_eff_master = r_master;
  assign w_eff_left   = r_left;
  assign w_eff_right  = r_right;
`endif

  lmc1992_gain u_gain_l (
    .i_clk    (clk32),
    .i_rst_n  (resb),
    .i_master (w_eff_master),
    .i_lr     (w_eff_left),
    .i_audio  (audio_in_l),
    .o_audio  (audio_out_l)
  );

  lmc1992_gain u_gain_r (
    .i_clk    (clk32),
    .i_rst_n  (resb),
    .i_master (w_eff_master),
    .i_lr     (w_eff_right),
    .i_audio  (audio_in_r),
    .o_audio  (audio_out_r)
  );

  assign master_vol = r_master;
  assign left_vol   = r_left;
  assign right_vol  = r_right;
  assign bass       = r_bass;
  assign treble     = r_treble;
  assign mix        = r_mix;
  assign frame_ok   = r_ok;
  assign frame_err  = r_err;

endmodule
